// File: rtl/audio_player.sv
// audio_player: multi-clip ROM sample player with PWM DAC; define AUDIO_PLAYER_VOLUME_EN to add a 4-bit volume input
module audio_player #(
  parameter int SAMPLE_W = 8,
  parameter int ADDR_W = 14,
  parameter int NUM_SOUNDS = 5,
  parameter logic [NUM_SOUNDS*ADDR_W-1:0] SOUND_BASE = '0,
  parameter logic [NUM_SOUNDS*ADDR_W-1:0] SOUND_LEN = '0,
  localparam int SEL_W = (NUM_SOUNDS > 1) ? $clog2(NUM_SOUNDS) : 1
) (
  input  logic                clk_25MHZ,
  input  logic                rst_n,
  input  logic                clk_8KHZ,
  input  logic [SEL_W-1:0]    sound_sel,
  input  logic                play,
  input  logic                loop,
  input  logic                stop,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic [SAMPLE_W-1:0] mem_data,
`ifdef AUDIO_PLAYER_VOLUME_EN
  input  logic [3:0]          volume,
`endif
  output logic                busy,
  output logic                done,
  output logic                pwm_out,
  output logic                en
);
  localparam logic [SAMPLE_W-1:0] MID = {1'b1, {(SAMPLE_W-1){1'b0}}};
  typedef enum logic {IDLE, PLAY} state_t;
  state_t state, next_state;
  logic [ADDR_W-1:0] req_base, req_len, base_r, len_r, remaining;
  logic loop_r, req_ok, do_play, do_stop, start, reject, tick, last;
  logic [SAMPLE_W-1:0] sample, cmp, cnt;
  // look up the requested clip; out-of-range selects read as length 0
  always_comb begin
    req_base = '0;
    req_len = '0;
    for (int i = 0; i < NUM_SOUNDS; i++)
      if (sound_sel == SEL_W'(i)) begin
        req_base = SOUND_BASE[i*ADDR_W +: ADDR_W];
        req_len = SOUND_LEN[i*ADDR_W +: ADDR_W];
      end
  end
  // request arbitration: stop beats play, play beats a coincident strobe
  always_comb begin
    req_ok = |req_len;
    do_play = play && !stop;
    do_stop = stop && state == PLAY;
    start = do_play && req_ok;
    reject = do_play && !req_ok;
    tick = state == PLAY && clk_8KHZ && !play && !stop;
    last = tick && remaining == '0 && !loop_r;
  end
  // state register
  always_ff @(posedge clk_25MHZ or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= next_state;
  // next-state logic
  always_comb next_state = start ? PLAY : (do_stop || reject || last) ? IDLE : state;
  // outputs decoded from state
  always_comb busy = state == PLAY;
  // clip address, remaining count, sample capture and done pulse
  always_ff @(posedge clk_25MHZ or negedge rst_n)
    if (!rst_n) begin
      mem_addr <= '0;
      remaining <= '0;
      base_r <= '0;
      len_r <= '0;
      loop_r <= 1'b0;
      sample <= MID;
      done <= 1'b0;
    end else begin
      done <= reject || last;
      if (start) begin
        mem_addr <= req_base;
        remaining <= req_len - ADDR_W'(1);
        base_r <= req_base;
        len_r <= req_len;
        loop_r <= loop;
      end else if (tick) begin
        sample <= mem_data;
        if (remaining != '0) begin
          mem_addr <= mem_addr + ADDR_W'(1);
          remaining <= remaining - ADDR_W'(1);
        end else if (loop_r) begin
          mem_addr <= base_r;
          remaining <= len_r - ADDR_W'(1);
        end
      end
      if (do_stop) sample <= MID;
    end
`ifdef AUDIO_PLAYER_VOLUME_EN
  localparam logic signed [SAMPLE_W+5:0] MID_X = {6'b0, MID};
  logic signed [SAMPLE_W+5:0] diff, prod;
  // signed offset from midscale scaled by volume/16
  always_comb begin
    diff = $signed({6'b0, sample}) - MID_X;
    prod = diff * $signed({{(SAMPLE_W+2){1'b0}}, volume});
  end
  // scaled compare value, one cycle behind the sample register
  always_ff @(posedge clk_25MHZ or negedge rst_n)
    if (!rst_n) cmp <= MID;
    else cmp <= SAMPLE_W'(MID_X + (prod >>> 4));
`else
  assign cmp = sample;
`endif
  // free-running PWM counter, registered comparator and amplifier enable
  always_ff @(posedge clk_25MHZ or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      pwm_out <= 1'b0;
      en <= 1'b0;
    end else begin
      cnt <= cnt + SAMPLE_W'(1);
      pwm_out <= cnt < cmp;
      en <= busy;
    end
endmodule

// File: tb/tb_audio_player.sv
// tb_audio_player: directed vector table plus randomized model-checked run for audio_player
module tb_audio_player;
  localparam int AW = 14;
  localparam int NS = 5;
  localparam logic [NS*AW-1:0] BASE = {14'd300, 14'd200, 14'd150, 14'd100, 14'd0};
  localparam logic [NS*AW-1:0] LEN = {14'd0, 14'd5, 14'd2, 14'd4, 14'd3};
  localparam int K_N = 0, K_P = 1, K_S = 2, K_T = 3, K_TP = 4, K_PS = 5;
  typedef struct {
    int k;
    int sel;
    bit lp;
    int addr;
    bit busy;
    bit done;
    int dsrc;
  } vec_t;
  logic clk_25MHZ = 0, rst_n = 0, clk_8KHZ = 0, play = 0, loop = 0, stop = 0;
  logic [2:0] sound_sel = 0;
  logic [13:0] mem_addr;
  logic [7:0] mem_data;
  logic busy, done, pwm_out, en;
`ifdef AUDIO_PLAYER_VOLUME_EN
  logic [3:0] volume = 4'd8;
`endif
  logic [7:0] rom [0:16383];
  int m_base [5] = '{0, 100, 150, 200, 300};
  int m_len [5] = '{3, 4, 2, 5, 0};
  int vecs = 0, errs = 0;
  vec_t tv [30];

  audio_player #(.SAMPLE_W(8), .ADDR_W(14), .NUM_SOUNDS(5), .SOUND_BASE(BASE), .SOUND_LEN(LEN)) dut (
    .clk_25MHZ(clk_25MHZ),
    .rst_n(rst_n),
    .clk_8KHZ(clk_8KHZ),
    .sound_sel(sound_sel),
    .play(play),
    .loop(loop),
    .stop(stop),
    .mem_addr(mem_addr),
    .mem_data(mem_data),
`ifdef AUDIO_PLAYER_VOLUME_EN
    .volume(volume),
`endif
    .busy(busy),
    .done(done),
    .pwm_out(pwm_out),
    .en(en)
  );

  always #20 clk_25MHZ = ~clk_25MHZ;
  always @(posedge clk_25MHZ) mem_data <= rom[mem_addr];

  function automatic int scale(int s);
`ifdef AUDIO_PLAYER_VOLUME_EN
    return 128 + (((s - 128) * int'(volume)) >>> 4);
`else
    return s;
`endif
  endfunction

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic act(int k, int sel, bit lp);
    @(negedge clk_25MHZ);
    sound_sel = 3'(sel);
    loop = lp;
    play = (k == K_P || k == K_TP || k == K_PS);
    stop = (k == K_T || k == K_TP);
    clk_8KHZ = (k == K_S || k == K_PS);
    @(negedge clk_25MHZ);
    play = 0;
    stop = 0;
    clk_8KHZ = 0;
  endtask

  task automatic duty(string name, int exp);
    int h = 0;
    repeat (4) @(negedge clk_25MHZ);
    for (int i = 0; i < 256; i++) begin
      @(negedge clk_25MHZ);
      h += int'(pwm_out);
    end
    chk(name, h, exp);
  endtask

  initial begin
    bit prev_busy;
    bit m_play, m_loop, m_done;
    int m_b, m_l, m_pos, m_addr, m_sample;
    for (int a = 0; a < 16384; a++) rom[a] = 8'(a * 37 + 11);
    rom[101] = 8'h40;
    rom[102] = 8'hC0;
    tv = '{
      '{K_P, 1, 0, 100, 1, 0, -1}, '{K_S, 0, 0, 101, 1, 0, 100}, '{K_S, 0, 0, 102, 1, 0, 101},
      '{K_S, 0, 0, 103, 1, 0, 102}, '{K_S, 0, 0, 103, 0, 1, 103}, '{K_P, 0, 1, 0, 1, 0, -1},
      '{K_S, 0, 0, 1, 1, 0, 0}, '{K_S, 0, 0, 2, 1, 0, 1}, '{K_S, 0, 0, 0, 1, 0, 2},
      '{K_S, 0, 0, 1, 1, 0, 0}, '{K_S, 0, 0, 2, 1, 0, 1}, '{K_S, 0, 0, 0, 1, 0, 2},
      '{K_S, 0, 0, 1, 1, 0, 0}, '{K_P, 1, 0, 100, 1, 0, -1}, '{K_T, 0, 0, 100, 0, 0, -2},
      '{K_P, 2, 0, 150, 1, 0, -1}, '{K_TP, 3, 0, 150, 0, 0, -2}, '{K_TP, 3, 0, 150, 0, 0, -2},
      '{K_PS, 3, 0, 200, 1, 0, -2}, '{K_S, 0, 0, 201, 1, 0, 200}, '{K_PS, 1, 0, 100, 1, 0, -1},
      '{K_S, 0, 0, 101, 1, 0, 100}, '{K_T, 0, 0, 101, 0, 0, -2}, '{K_P, 5, 0, 101, 0, 1, -2},
      '{K_P, 4, 1, 101, 0, 1, -2}, '{K_N, 0, 0, 101, 0, 0, -1}, '{K_P, 2, 0, 150, 1, 0, -1},
      '{K_S, 0, 0, 151, 1, 0, 150}, '{K_S, 0, 0, 151, 0, 1, 151}, '{K_N, 0, 0, 151, 0, 0, 151}
    };
    repeat (3) @(negedge clk_25MHZ);
    chk("reset mem_addr", mem_addr, 0);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset pwm_out", pwm_out, 0);
    chk("reset en", en, 0);
    rst_n = 1;
    duty("reset midscale duty", scale(128));
    prev_busy = 0;
    for (int i = 0; i < 30; i++) begin
      act(tv[i].k, tv[i].sel, tv[i].lp);
      chk($sformatf("row%0d mem_addr", i), mem_addr, tv[i].addr);
      chk($sformatf("row%0d busy", i), busy, tv[i].busy);
      chk($sformatf("row%0d done", i), done, tv[i].done);
      chk($sformatf("row%0d en", i), en, prev_busy);
      prev_busy = tv[i].busy;
      if (tv[i].dsrc == -2) duty($sformatf("row%0d duty", i), scale(128));
      else if (tv[i].dsrc >= 0) duty($sformatf("row%0d duty", i), scale(int'(rom[tv[i].dsrc])));
      else repeat (4) @(negedge clk_25MHZ);
    end
    @(negedge clk_25MHZ);
    chk("en follows busy", en, 0);
    act(K_P, 1, 0);
    repeat (4) @(negedge clk_25MHZ);
    act(K_S, 0, 0);
    repeat (4) @(negedge clk_25MHZ);
    act(K_S, 0, 0);
    #3 rst_n = 0;
    #1;
    chk("async reset mem_addr", mem_addr, 0);
    chk("async reset busy", busy, 0);
    chk("async reset done", done, 0);
    chk("async reset pwm_out", pwm_out, 0);
    chk("async reset en", en, 0);
    repeat (3) @(negedge clk_25MHZ);
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_25MHZ);
      chk("post reset done", done, 0);
      chk("post reset busy", busy, 0);
    end
    duty("post reset duty", scale(128));
    m_play = 0;
    m_loop = 0;
    m_b = 0;
    m_l = 0;
    m_pos = 0;
    m_addr = 0;
    m_sample = 128;
    prev_busy = 0;
    for (int n = 0; n < 40; n++) begin
      int k, sel;
      bit lp, valid, pl, st, sb;
      k = $urandom_range(0, 5);
      sel = $urandom_range(0, 5);
      lp = 1'($urandom_range(0, 1));
      valid = sel < 5 && m_len[sel] != 0;
      if (m_play && !valid && (k == K_P || k == K_PS)) begin
        sel = 1;
        valid = 1;
      end
`ifdef AUDIO_PLAYER_VOLUME_EN
      volume = 4'($urandom);
`endif
      act(k, sel, lp);
      pl = (k == K_P || k == K_TP || k == K_PS);
      st = (k == K_T || k == K_TP);
      sb = (k == K_S || k == K_PS);
      m_done = 0;
      if (st) begin
        if (m_play) m_sample = 128;
        m_play = 0;
      end else if (pl) begin
        if (valid) begin
          m_play = 1;
          m_b = m_base[sel];
          m_l = m_len[sel];
          m_loop = lp;
          m_pos = 0;
          m_addr = m_b;
        end else m_done = 1;
      end else if (sb && m_play) begin
        m_sample = int'(rom[(m_b + m_pos) % 16384]);
        m_pos++;
        if (m_pos == m_l) begin
          if (m_loop) m_pos = 0;
          else begin
            m_play = 0;
            m_done = 1;
          end
        end
        if (m_play) m_addr = (m_b + m_pos) % 16384;
      end
      chk($sformatf("rand%0d mem_addr", n), mem_addr, m_addr);
      chk($sformatf("rand%0d busy", n), busy, m_play);
      chk($sformatf("rand%0d done", n), done, m_done);
      chk($sformatf("rand%0d en", n), en, prev_busy);
      prev_busy = m_play;
      duty($sformatf("rand%0d duty", n), scale(m_sample));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
